neuron_seq_ctrl: RTL and testbench
==================================

Name: neuron_seq_ctrl

Overview:
Sequential controller for one fully-connected neuron. It replaces the flat combinational 784-term dot product with a single time-shared multiply-accumulate. On start it streams N_INPUTS activation/weight pairs from external synchronous RAMs and accumulates them. It then adds the bias, rescales, clamps the result to 0..255 and reports completion. It sits between the layer sequencer (start/done) and the activation and weight memories.

Parameters:
N_INPUTS, 784, number of input/weight pairs per neuron (1..2^ADDR_W)
ADDR_W, 10, address width of both memories
ACC_W, 36, signed accumulator width; wide enough that 784 × 255 × (−32768) cannot overflow
SHIFT, 0, arithmetic right shift applied to the accumulator before the bias add (fixed-point rescale)

Ports:
clk  input  1  clock; all logic updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to compute a neuron; honoured only in IDLE
bias  input  8  signed bias, captured on the edge that accepts start
in_rd_en  output  1  read strobe to activation RAM
in_addr  output  ADDR_W  activation RAM address
in_data  input  8  unsigned activation; valid 1 cycle after in_rd_en
wt_rd_en  output  1  read strobe to weight RAM (identical to in_rd_en)
wt_addr  output  ADDR_W  weight RAM address (identical to in_addr)
wt_data  input  16  signed weight; valid 1 cycle after wt_rd_en
busy  output  1  high while a computation is in progress
done  output  1  one-cycle completion pulse
out_data  output  8  clamped neuron output; held until the next accepted start or reset

Behaviour:
- Reset: state=IDLE; acc=0; in_addr/wt_addr=0; in_rd_en, wt_rd_en, busy, done=0; out_data=0. Reset overrides everything. A reset mid-run aborts silently: no done pulse, and out_data is cleared.
- States:
  - IDLE: start=1 → RUN. On that edge: capture bias, clear acc, set addr=0, raise rd_en, raise busy.
  - RUN: issues addresses 0..N_INPUTS−1 on consecutive cycles. When the last address is issued → DRAIN, and rd_en drops.
  - DRAIN: one cycle to absorb the final read's data → FINISH.
  - FINISH: one cycle. Registers out_data and pulses done=1. busy stays 1 during this cycle → IDLE.
- MAC pipeline:
  - A registered valid bit follows rd_en by one cycle.
  - When valid=1: acc += sign_extend(wt_data) × zero_extend(in_data).
  - The product is a 25-bit signed value, sign-extended to ACC_W.
- Timing: let E0 be the edge that accepts start.
  - rd_en is high in cycles E0..E0+N−1, with addr k in cycle E0+k.
  - The last product is accumulated at edge E0+N+1.
  - done is high in the cycle following edge E0+N+2.
  - busy falls at edge E0+N+3, with done.
  - Total start-to-done latency is N_INPUTS+2 cycles.
- Result:
  - r = (acc >>> SHIFT) + sign_extend(bias), computed at ACC_W+1 bits signed.
  - out_data = 0 if r<0; 255 if r>255; otherwise r[7:0].
- start while busy (including the FINISH cycle) is ignored. No queuing.
- A start arriving in the cycle after done is accepted normally; back-to-back neurons are allowed.
- in_data/wt_data are ignored whenever valid=0.
- N_INPUTS=1: a single RUN cycle, then DRAIN, then FINISH. The same latency formula applies.

Test Plan:
- N_INPUTS=4, in=[10,20,30,40], wt=[1,2,−1,1], bias=5, SHIFT=0, start at E0 → acc=60, r=65. Expect out_data=65 and done high exactly 6 cycles after E0. Addresses 0,1,2,3 appear on consecutive cycles.
- N_INPUTS=784, all in=255, all wt=32767, bias=127 → no accumulator overflow; out_data=255 (saturate high).
- N_INPUTS=4, in=[255]×4, wt=[−32768]×4, bias=127 → r negative; out_data=0, done pulses once.
- N_INPUTS=4, SHIFT=8, in=[1]×4, wt=[256]×4, bias=3 → acc=1024, 1024>>>8=4, r=7; out_data=7.
- Pulse start again 2 cycles after the first accept, then hold start high across FINISH → only one done per accepted start. The second computation starts the cycle after done and uses the newly captured bias.
- Assert rst at E0+2 during RUN → next cycle busy=0, rd_en=0, out_data=0, and no done pulse. A fresh start then completes normally with the correct result.

Source files
------------

// File: rtl/neuron_seq_ctrl.sv
// Time-shared multiply-accumulate controller for one fully-connected neuron.
// Streams activation/weight pairs from synchronous RAMs, adds bias, rescales and clamps to 0..255.
module neuron_seq_ctrl #(
    parameter int N_INPUTS = 784,
    parameter int ADDR_W   = 10,
    parameter int ACC_W    = 36,
    parameter int SHIFT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        bias,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    output logic              wt_rd_en,
    output logic [ADDR_W-1:0] wt_addr,
    input  logic [15:0]       wt_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        out_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_INPUTS - 1);

    state_t                   state_r;
    state_t                   state_s;
    logic                     accept_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic        [7:0]        bias_r;
    logic        [ADDR_W-1:0] addr_r;
    logic                     rd_en_r;
    logic                     valid_r;
    logic                     busy_r;
    logic                     done_r;
    logic        [7:0]        out_r;
    logic signed [24:0]       wt_ext_s;
    logic signed [24:0]       act_ext_s;
    logic signed [24:0]       prod_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic        [ACC_W:0]    sum_s;
    logic        [7:0]        clamp_s;

    function automatic logic [7:0] clamp_u8(input logic [ACC_W:0] v);
        if (v[ACC_W]) begin
            return 8'd0;
        end else if (|v[ACC_W-1:8]) begin
            return 8'd255;
        end else begin
            return v[7:0];
        end
    endfunction

    // Next-state logic; start is only honoured once busy has dropped after the done cycle
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !busy_r) begin
                    accept_s = 1'b1;
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                if (addr_r == LAST_ADDR) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN:   state_s = FINISH;
            FINISH:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Product, rescale and saturation of the accumulated sum
    always_comb begin
        wt_ext_s  = {{9{wt_data[15]}}, wt_data};
        act_ext_s = {17'd0, in_data};
        prod_s    = wt_ext_s * act_ext_s;
        shifted_s = acc_r >>> SHIFT;
        sum_s     = {shifted_s[ACC_W-1], shifted_s} + {{(ACC_W - 7){bias_r[7]}}, bias_r};
        clamp_s   = clamp_u8(sum_s);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Address issue, MAC pipeline and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= '0;
            bias_r  <= 8'd0;
            addr_r  <= '0;
            rd_en_r <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            out_r   <= 8'd0;
        end else begin
            valid_r <= rd_en_r;
            done_r  <= 1'b0;
            if (accept_s) begin
                bias_r  <= bias;
                acc_r   <= '0;
                addr_r  <= '0;
                rd_en_r <= 1'b1;
                busy_r  <= 1'b1;
            end else begin
                if (valid_r) begin
                    acc_r <= acc_r + {{(ACC_W - 25){prod_s[24]}}, prod_s};
                end
                if (state_r == RUN) begin
                    if (addr_r == LAST_ADDR) begin
                        rd_en_r <= 1'b0;
                    end else begin
                        addr_r <= addr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
                    end
                end
                if (state_r == FINISH) begin
                    done_r <= 1'b1;
                    out_r  <= clamp_s;
                end
                // busy covers the done cycle so a start there is ignored
                if (done_r) begin
                    busy_r <= 1'b0;
                end
            end
        end
    end

    assign in_rd_en = rd_en_r;
    assign wt_rd_en = rd_en_r;
    assign in_addr  = addr_r;
    assign wt_addr  = addr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign out_data = out_r;

endmodule

// File: tb/tb_neuron_seq_ctrl.sv
// Bench for neuron_seq_ctrl: four instances (N=4, N=784, N=4 with SHIFT=8, N=1) fed by modelled RAMs,
// results compared against an arithmetic dot-product/clamp model.
module tb_neuron_seq_ctrl;

    localparam int NI [4] = '{4, 784, 4, 1};
    localparam int SH [4] = '{0, 0, 8, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start     [4];
    logic [7:0]  bias      [4];
    logic        in_rd_en  [4];
    logic        wt_rd_en  [4];
    logic [9:0]  in_addr   [4];
    logic [9:0]  wt_addr   [4];
    logic [7:0]  in_data   [4];
    logic [15:0] wt_data   [4];
    logic        busy      [4];
    logic        done      [4];
    logic [7:0]  out_data  [4];

    logic [7:0]  amem [4][1024];
    logic [15:0] wmem [4][1024];

    int   cyc = 0;
    int   done_cnt     [4];
    int   done_cyc     [4];
    logic busy_at_done [4];
    int   same_diff    [4];
    int   addr_q[$];
    int   addr_cyc_q[$];
    int   dq_cyc[$];
    int   dq_res[$];
    int   n_vec = 0;
    int   n_fail = 0;

    neuron_seq_ctrl #(.N_INPUTS(4), .ADDR_W(10), .ACC_W(36), .SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .bias(bias[0]),
        .in_rd_en(in_rd_en[0]), .in_addr(in_addr[0]), .in_data(in_data[0]),
        .wt_rd_en(wt_rd_en[0]), .wt_addr(wt_addr[0]), .wt_data(wt_data[0]),
        .busy(busy[0]), .done(done[0]), .out_data(out_data[0]));
    neuron_seq_ctrl #(.N_INPUTS(784), .ADDR_W(10), .ACC_W(36), .SHIFT(0)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .bias(bias[1]),
        .in_rd_en(in_rd_en[1]), .in_addr(in_addr[1]), .in_data(in_data[1]),
        .wt_rd_en(wt_rd_en[1]), .wt_addr(wt_addr[1]), .wt_data(wt_data[1]),
        .busy(busy[1]), .done(done[1]), .out_data(out_data[1]));
    neuron_seq_ctrl #(.N_INPUTS(4), .ADDR_W(10), .ACC_W(36), .SHIFT(8)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .bias(bias[2]),
        .in_rd_en(in_rd_en[2]), .in_addr(in_addr[2]), .in_data(in_data[2]),
        .wt_rd_en(wt_rd_en[2]), .wt_addr(wt_addr[2]), .wt_data(wt_data[2]),
        .busy(busy[2]), .done(done[2]), .out_data(out_data[2]));
    neuron_seq_ctrl #(.N_INPUTS(1), .ADDR_W(10), .ACC_W(36), .SHIFT(0)) u3 (
        .clk(clk), .rst(rst), .start(start[3]), .bias(bias[3]),
        .in_rd_en(in_rd_en[3]), .in_addr(in_addr[3]), .in_data(in_data[3]),
        .wt_rd_en(wt_rd_en[3]), .wt_addr(wt_addr[3]), .wt_data(wt_data[3]),
        .busy(busy[3]), .done(done[3]), .out_data(out_data[3]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAMs: data one cycle after the read strobe, garbage otherwise
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (in_rd_en[i] === 1'b1) begin
                in_data[i] <= amem[i][in_addr[i]];
                wt_data[i] <= wmem[i][wt_addr[i]];
            end else begin
                in_data[i] <= 8'($urandom);
                wt_data[i] <= 16'($urandom);
            end
        end
    end

    // Event recorder, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done[i] === 1'b1) begin
                done_cnt[i]     = done_cnt[i] + 1;
                done_cyc[i]     = cyc;
                busy_at_done[i] = busy[i];
                if (i == 0) begin
                    dq_cyc.push_back(cyc);
                    dq_res.push_back(int'(out_data[0]));
                end
            end
            if (in_rd_en[i] !== wt_rd_en[i] || in_addr[i] !== wt_addr[i]) same_diff[i] = same_diff[i] + 1;
        end
        if (in_rd_en[0] === 1'b1) begin
            addr_q.push_back(int'(in_addr[0]));
            addr_cyc_q.push_back(cyc);
        end
    end

    function automatic int model(input int i, input int b);
        longint s = 0;
        for (int k = 0; k < NI[i]; k++) s += longint'($signed(wmem[i][k])) * longint'(amem[i][k]);
        s = s >>> SH[i];
        s = s + longint'(b);
        if (s < 0) return 0;
        if (s > 255) return 255;
        return int'(s);
    endfunction

    task automatic launch(input int i, input int b, output int e0);
        start[i] = 1'b1;
        bias[i]  = 8'(b);
        @(posedge clk); #1;
        e0       = cyc;
        start[i] = 1'b0;
        bias[i]  = 8'($urandom);
    endtask

    task automatic wait_done(input int i, input int prev, input int budget, output bit ok);
        int k = 0;
        while (done_cnt[i] == prev && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        ok = (done_cnt[i] != prev);
    endtask

    task automatic run_neuron(input int i, input int b, output int res, output int lat, output bit ok);
        int e0;
        int prev = done_cnt[i];
        launch(i, b, e0);
        wait_done(i, prev, NI[i] + 20, ok);
        res = int'(out_data[i]);
        lat = done_cyc[i] - e0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({busy[i], done[i], in_rd_en[i], wt_rd_en[i], in_addr[i], out_data[i]} !== 22'd0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got busy=%b done=%b rd=%b/%b addr=%0d out=%0d expected all zero",
                         i, busy[i], done[i], in_rd_en[i], wt_rd_en[i], in_addr[i], out_data[i]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int a [4] = '{10, 20, 30, 40};
        int w [4] = '{1, 2, -1, 1};
        int res, lat;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            amem[0][k] = 8'(a[k]);
            wmem[0][k] = 16'(w[k]);
        end
        addr_q.delete();
        addr_cyc_q.delete();
        run_neuron(0, 5, res, lat, ok);
        n_vec++;
        if (!ok || res !== 65) begin
            n_fail++;
            $display("FAIL basic_result: got %0d (done=%0d) expected 65", res, ok);
        end
        n_vec++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected 6", lat);
        end
        n_vec++;
        if (addr_q.size() != 4) begin
            n_fail++;
            $display("FAIL basic_addr_count: got %0d expected 4", addr_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (addr_q[k] != k || addr_cyc_q[k] != done_cyc[0] - 6 + k) begin
                    n_fail++;
                    $display("FAIL basic_addr[%0d]: got addr %0d at cycle %0d expected addr %0d at cycle %0d",
                             k, addr_q[k], addr_cyc_q[k], k, done_cyc[0] - 6 + k);
                end
            end
        end
        n_vec++;
        if (busy_at_done[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy: got busy_at_done=%b busy_after=%b done_after=%b expected 1 0 0",
                     busy_at_done[0], busy[0], done[0]);
        end
    endtask

    task automatic test_saturate_high();
        int res, lat;
        bit ok;
        for (int k = 0; k < 784; k++) begin
            amem[1][k] = 8'd255;
            wmem[1][k] = 16'd32767;
        end
        run_neuron(1, 127, res, lat, ok);
        n_vec++;
        if (!ok || res !== 255) begin
            n_fail++;
            $display("FAIL sat_high_result: got %0d expected 255", res);
        end
        n_vec++;
        if (lat !== 786) begin
            n_fail++;
            $display("FAIL sat_high_latency: got %0d expected 786", lat);
        end
    endtask

    task automatic test_saturate_low();
        int res, lat, prev;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            amem[0][k] = 8'd255;
            wmem[0][k] = 16'h8000;
        end
        prev = done_cnt[0];
        run_neuron(0, 127, res, lat, ok);
        n_vec++;
        if (!ok || res !== 0) begin
            n_fail++;
            $display("FAIL sat_low_result: got %0d expected 0", res);
        end
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if (done_cnt[0] != prev + 1) begin
            n_fail++;
            $display("FAIL sat_low_done_count: got %0d expected 1", done_cnt[0] - prev);
        end
    endtask

    task automatic test_shift();
        int res, lat;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            amem[2][k] = 8'd1;
            wmem[2][k] = 16'd256;
        end
        run_neuron(2, 3, res, lat, ok);
        n_vec++;
        if (!ok || res !== 7 || lat !== 6) begin
            n_fail++;
            $display("FAIL shift_result: got %0d latency %0d expected 7 latency 6", res, lat);
        end
    endtask

    task automatic test_random();
        int ids [3] = '{0, 2, 3};
        int res, lat, b, exp_res;
        bit ok;
        for (int rep = 0; rep < 12; rep++) begin
            foreach (ids[j]) begin
                int i = ids[j];
                for (int k = 0; k < NI[i]; k++) begin
                    amem[i][k] = 8'($urandom);
                    wmem[i][k] = (rep % 2 == 1) ? 16'($urandom) : 16'(int'($urandom_range(0, 64)) - 32);
                end
                b = int'($urandom_range(0, 255)) - 128;
                exp_res = model(i, b);
                run_neuron(i, b, res, lat, ok);
                n_vec++;
                if (!ok || res !== exp_res || lat !== NI[i] + 2) begin
                    n_fail++;
                    $display("FAIL random[%0d] inst %0d: got %0d latency %0d expected %0d latency %0d",
                             rep, i, res, lat, exp_res, NI[i] + 2);
                end
            end
        end
        n_vec++;
        if (same_diff[0] + same_diff[1] + same_diff[2] + same_diff[3] != 0) begin
            n_fail++;
            $display("FAIL rd_port_match: got %0d differing cycles expected 0",
                     same_diff[0] + same_diff[1] + same_diff[2] + same_diff[3]);
        end
    endtask

    task automatic test_back_to_back();
        int e0, b1, b2, exp1, exp2, base;
        for (int k = 0; k < 4; k++) begin
            amem[0][k] = 8'($urandom);
            wmem[0][k] = 16'(int'($urandom_range(0, 40)) - 10);
        end
        b1 = int'($urandom_range(0, 100)) - 50;
        b2 = b1 + 60;
        exp1 = model(0, b1);
        exp2 = model(0, b2);
        base = dq_cyc.size();
        launch(0, b1, e0);
        @(posedge clk); #1;
        start[0] = 1'b1;
        bias[0]  = 8'(b1 - 40);
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start[0] = 1'b1;
        bias[0]  = 8'(b2);
        while (cyc < e0 + 8) begin
            @(posedge clk); #1;
        end
        start[0] = 1'b0;
        bias[0]  = 8'($urandom);
        while (cyc < e0 + 24) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (dq_cyc.size() - base != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d expected 2", dq_cyc.size() - base);
        end else begin
            n_vec++;
            if (dq_cyc[base] != e0 + 6 || dq_res[base] != exp1) begin
                n_fail++;
                $display("FAIL b2b_first: got %0d at cycle %0d expected %0d at cycle %0d",
                         dq_res[base], dq_cyc[base], exp1, e0 + 6);
            end
            n_vec++;
            if (dq_cyc[base + 1] != e0 + 14 || dq_res[base + 1] != exp2) begin
                n_fail++;
                $display("FAIL b2b_second: got %0d at cycle %0d expected %0d at cycle %0d",
                         dq_res[base + 1], dq_cyc[base + 1], exp2, e0 + 14);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int a [4] = '{10, 20, 30, 40};
        int w [4] = '{1, 2, -1, 1};
        int res, lat, e0, prev;
        bit ok;
        for (int k = 0; k < 4; k++) begin
            amem[0][k] = 8'(a[k]);
            wmem[0][k] = 16'(w[k]);
        end
        run_neuron(0, 5, res, lat, ok);
        prev = done_cnt[0];
        launch(0, 5, e0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (busy[0] !== 1'b0 || in_rd_en[0] !== 1'b0 || out_data[0] !== 8'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b rd=%b out=%0d expected 0 0 0 (prior out %0d)",
                     busy[0], in_rd_en[0], out_data[0], res);
        end
        repeat (12) @(posedge clk);
        #1;
        n_vec++;
        if (done_cnt[0] != prev) begin
            n_fail++;
            $display("FAIL midrun_no_done: got %0d done pulses expected 0", done_cnt[0] - prev);
        end
        run_neuron(0, 5, res, lat, ok);
        n_vec++;
        if (!ok || res !== 65 || lat !== 6) begin
            n_fail++;
            $display("FAIL midrun_restart: got %0d latency %0d expected 65 latency 6", res, lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            bias[i]  = 8'd0;
        end
        test_reset();
        test_basic();
        test_saturate_high();
        test_saturate_low();
        test_shift();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
